// File: rtl/class_score_accum_if.sv
// Pixel/weight stream in, ten class scores out.
// Master drives the stream; slave is the accumulator.
interface class_score_accum_if #(
  parameter int PIX_W = 8,
  parameter int WT_W  = 8,
  parameter int ACC_W = 26
);
  logic               start;
  logic [PIX_W-1:0]   pixel;
  logic [10*WT_W-1:0] weights;
  logic               in_valid;
  logic               in_ready;
  logic               busy;
  logic [ACC_W-1:0]   final0;
  logic [ACC_W-1:0]   final1;
  logic [ACC_W-1:0]   final2;
  logic [ACC_W-1:0]   final3;
  logic [ACC_W-1:0]   final4;
  logic [ACC_W-1:0]   final5;
  logic [ACC_W-1:0]   final6;
  logic [ACC_W-1:0]   final7;
  logic [ACC_W-1:0]   final8;
  logic [ACC_W-1:0]   final9;
  logic               scores_valid;

  modport master (
    output start, pixel, weights, in_valid,
    input  in_ready, busy, scores_valid,
    input  final0, final1, final2, final3, final4,
    input  final5, final6, final7, final8, final9
  );

  modport slave (
    input  start, pixel, weights, in_valid,
    output in_ready, busy, scores_valid,
    output final0, final1, final2, final3, final4,
    output final5, final6, final7, final8, final9
  );
endinterface

// File: rtl/class_score_accum.sv
// Ten-class dot-product score generator:
// pixel*weight products, saturating accumulate.
module class_score_accum #(
  parameter int N_IN  = 784,
  parameter int PIX_W = 8,
  parameter int WT_W  = 8,
  parameter int ACC_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  class_score_accum_if.slave bus
);
  localparam int P_W = PIX_W + WT_W;
  localparam int S_W =
    ((ACC_W > P_W) ? ACC_W : P_W) + 1;
  localparam int CNT_W =
    (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_IN - 1);
  localparam logic [S_W-1:0] SAT =
    {{(S_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE, ACCUM, DRAIN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   prod   [10];
  logic             prod_valid;
  logic [ACC_W-1:0] acc    [10];
  logic [ACC_W-1:0] acc_nx [10];
  logic [S_W-1:0]   sum    [10];
  logic [ACC_W-1:0] fin    [10];
  logic             scores_valid;
  logic             accept;
  logic             start_ok;
  logic             last_beat;

  assign bus.in_ready = (state == ACCUM);
  assign bus.busy     = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_beat    = accept && (cnt == LAST);
  // A start coinciding with the score pulse is dropped.
  assign start_ok     = (state == IDLE) && bus.start
                        && !scores_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok)  state_nx = ACCUM;
      ACCUM:   if (last_beat) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      sum[k] = {{(S_W-ACC_W){1'b0}}, acc[k]}
             + {{(S_W-P_W){1'b0}}, prod[k]};
      acc_nx[k] = acc[k];
      if (prod_valid) begin
        if (sum[k] > SAT) acc_nx[k] = '1;
        else              acc_nx[k] = sum[k][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      prod_valid   <= 1'b0;
      scores_valid <= 1'b0;
      for (int k = 0; k < 10; k++) begin
        prod[k] <= '0;
        acc[k]  <= '0;
        fin[k]  <= '0;
      end
    end else begin
      prod_valid   <= accept;
      scores_valid <= (state == DRAIN);
      if (start_ok)
        cnt <= '0;
      else if (accept && !last_beat)
        cnt <= cnt + CNT_W'(1);
      for (int k = 0; k < 10; k++) begin
        if (accept)
          prod[k] <= P_W'(bus.pixel)
                   * P_W'(bus.weights[WT_W*k +: WT_W]);
        if (start_ok) acc[k] <= '0;
        else          acc[k] <= acc_nx[k];
        // Last product folds in while loading scores.
        if (state == DRAIN) fin[k] <= acc_nx[k];
      end
    end
  end

  assign bus.scores_valid = scores_valid;
  assign bus.final0 = fin[0];
  assign bus.final1 = fin[1];
  assign bus.final2 = fin[2];
  assign bus.final3 = fin[3];
  assign bus.final4 = fin[4];
  assign bus.final5 = fin[5];
  assign bus.final6 = fin[6];
  assign bus.final7 = fin[7];
  assign bus.final8 = fin[8];
  assign bus.final9 = fin[9];
endmodule

// File: tb/tb_class_score_accum.sv
// Scoreboard bench: three configurations, queued
// expected score vectors popped on scores_valid.
module tb_class_score_accum;
  typedef logic [9:0][25:0] vec_t;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rbig = 1'b1;
  logic rsat = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  vec_t q4[$];
  int   t4[$];
  vec_t qb[$];
  int   tb_[$];
  vec_t qs[$];
  int   ts[$];
  vec_t held4 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  class_score_accum_if #(.ACC_W(26)) b4();
  class_score_accum_if #(.ACC_W(26)) bb();
  class_score_accum_if #(.ACC_W(12)) bs();

  class_score_accum #(.N_IN(4), .ACC_W(26)) u4 (
    .clk(clk), .reset(rst4), .bus(b4));
  class_score_accum #(.N_IN(784), .ACC_W(26)) ubig (
    .clk(clk), .reset(rbig), .bus(bb));
  class_score_accum #(.N_IN(4), .ACC_W(12)) usat (
    .clk(clk), .reset(rsat), .bus(bs));

  task automatic chk(input string name,
                     input logic [259:0] act,
                     input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic vec_t g4();
    vec_t v;
    v[0] = b4.final0; v[1] = b4.final1;
    v[2] = b4.final2; v[3] = b4.final3;
    v[4] = b4.final4; v[5] = b4.final5;
    v[6] = b4.final6; v[7] = b4.final7;
    v[8] = b4.final8; v[9] = b4.final9;
    return v;
  endfunction

  function automatic vec_t gb();
    vec_t v;
    v[0] = bb.final0; v[1] = bb.final1;
    v[2] = bb.final2; v[3] = bb.final3;
    v[4] = bb.final4; v[5] = bb.final5;
    v[6] = bb.final6; v[7] = bb.final7;
    v[8] = bb.final8; v[9] = bb.final9;
    return v;
  endfunction

  function automatic vec_t gs();
    vec_t v;
    v[0] = 26'(bs.final0); v[1] = 26'(bs.final1);
    v[2] = 26'(bs.final2); v[3] = 26'(bs.final3);
    v[4] = 26'(bs.final4); v[5] = 26'(bs.final5);
    v[6] = 26'(bs.final6); v[7] = 26'(bs.final7);
    v[8] = 26'(bs.final8); v[9] = 26'(bs.final9);
    return v;
  endfunction

  // exp[k] = mul * (k + off)
  function automatic vec_t mk(input int mul,
                              input int off);
    vec_t v;
    for (int k = 0; k < 10; k++)
      v[k] = 26'(mul * (k + off));
    return v;
  endfunction

  function automatic vec_t uni(input int x);
    vec_t v;
    for (int k = 0; k < 10; k++) v[k] = 26'(x);
    return v;
  endfunction

  function automatic logic [79:0] wts(input int off);
    logic [79:0] w;
    for (int k = 0; k < 10; k++)
      w[8*k +: 8] = 8'(k + off);
    return w;
  endfunction

  task automatic monitor();
    vec_t e;
    int   t;
    forever begin
      @(negedge clk);
      if (b4.scores_valid) begin
        if (q4.size() == 0) begin
          chk("u4_unexpected_valid", 1, 0);
        end else begin
          e = q4.pop_front();
          t = t4.pop_front();
          chk("u4_latency", cyc, t);
          chk("u4_scores", g4(), e);
          held4 = e;
        end
      end else begin
        chk("u4_hold", g4(), held4);
      end
      if (rst4) held4 = '0;
      if (bb.scores_valid) begin
        if (qb.size() == 0) begin
          chk("big_unexpected_valid", 1, 0);
        end else begin
          e = qb.pop_front();
          t = tb_.pop_front();
          chk("big_latency", cyc, t);
          chk("big_scores", gb(), e);
        end
      end
      if (bs.scores_valid) begin
        if (qs.size() == 0) begin
          chk("sat_unexpected_valid", 1, 0);
        end else begin
          e = qs.pop_front();
          t = ts.pop_front();
          chk("sat_latency", cyc, t);
          chk("sat_scores", gs(), e);
        end
      end
    end
  endtask

  task automatic start4();
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    chk("u4_busy_after_start", b4.busy, 1);
  endtask

  task automatic beat4(input logic [7:0] p,
                       input logic [79:0] w);
    b4.pixel    = p;
    b4.weights  = w;
    b4.in_valid = 1'b1;
    chk("u4_in_ready", b4.in_ready, 1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic drain4();
    for (int i = 0; i < 20 && q4.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("u4_drained", q4.size(), 0);
    chk("u4_idle", b4.busy, 0);
  endtask

  initial begin
    b4.start = 0; b4.pixel = 0;
    b4.weights = 0; b4.in_valid = 0;
    bb.start = 0; bb.pixel = 0;
    bb.weights = 0; bb.in_valid = 0;
    bs.start = 0; bs.pixel = 0;
    bs.weights = 0; bs.in_valid = 0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst4 = 0; rbig = 0; rsat = 0;
    chk("rst_in_ready", b4.in_ready, 0);
    chk("rst_busy", b4.busy, 0);
    chk("rst_valid", b4.scores_valid, 0);
    chk("rst_finals", g4(), '0);

    // image 1: pixels 1..4, weight_k = k
    start4();
    beat4(8'd1, wts(0));
    beat4(8'd2, wts(0));
    beat4(8'd3, wts(0));
    beat4(8'd4, wts(0));
    q4.push_back(mk(10, 0));
    t4.push_back(cyc + 1);
    chk("u4_drain_ready", b4.in_ready, 0);
    @(posedge clk); #1;
    chk("u4_valid_now", b4.scores_valid, 1);
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    chk("u4_start_at_valid", b4.busy, 0);
    drain4();

    // image 2: 3-cycle gap between beats 2 and 3
    start4();
    beat4(8'd1, wts(0));
    beat4(8'd2, wts(0));
    repeat (3) begin
      b4.pixel = 8'hAA;
      chk("u4_gap_ready", b4.in_ready, 1);
      @(posedge clk); #1;
    end
    beat4(8'd3, wts(0));
    beat4(8'd4, wts(0));
    q4.push_back(mk(10, 0));
    t4.push_back(cyc + 1);
    drain4();

    // image 3: stray start mid-image; old scores hold
    start4();
    beat4(8'd5, wts(1));
    b4.start = 1'b1;
    beat4(8'd6, wts(1));
    b4.start = 1'b0;
    beat4(8'd7, wts(1));
    beat4(8'd8, wts(1));
    q4.push_back(mk(26, 1));
    t4.push_back(cyc + 1);
    drain4();

    // image 4: reset after beat 2, then fresh image
    start4();
    beat4(8'd9, {10{8'd7}});
    beat4(8'd9, {10{8'd7}});
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("midrst_busy", b4.busy, 0);
    chk("midrst_ready", b4.in_ready, 0);
    chk("midrst_valid", b4.scores_valid, 0);
    chk("midrst_finals", g4(), '0);
    repeat (5) @(posedge clk);
    #1;
    start4();
    beat4(8'd10, wts(0));
    beat4(8'd20, wts(0));
    beat4(8'd30, wts(0));
    beat4(8'd40, wts(0));
    q4.push_back(mk(100, 0));
    t4.push_back(cyc + 1);
    drain4();

    // 784 beats of 255*255: no saturation
    bb.start = 1'b1;
    @(posedge clk); #1;
    bb.start = 1'b0;
    bb.pixel = 8'hFF;
    bb.weights = {10{8'hFF}};
    bb.in_valid = 1'b1;
    repeat (784) @(posedge clk);
    #1;
    bb.in_valid = 1'b0;
    qb.push_back(uni(50979600));
    tb_.push_back(cyc + 1);
    for (int i = 0; i < 20 && qb.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("big_drained", qb.size(), 0);

    // 12-bit accumulator saturates at 4095
    bs.start = 1'b1;
    @(posedge clk); #1;
    bs.start = 1'b0;
    bs.pixel = 8'hFF;
    bs.weights = {10{8'hFF}};
    bs.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bs.in_valid = 1'b0;
    qs.push_back(uni(4095));
    ts.push_back(cyc + 1);
    for (int i = 0; i < 20 && qs.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("sat_drained", qs.size(), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/class_score_accum.md
Name: class_score_accum

Overview:
- Output-layer score generator for the 10-class digit classifier; the producer side of the final0..final9 score bus that the argmax comparator consumes.
- Accepts a stream of 8-bit pixels, each with 10 per-class 8-bit weights, and forms 10 unsigned dot products.
- Presents the 26-bit totals on final0..final9, held stable with a one-cycle valid pulse.

Parameters:
- N_IN, 784, pixels per image; 1..1023.
- PIX_W, 8, pixel width (unsigned).
- WT_W, 8, weight width (unsigned).
- ACC_W, 26, accumulator and score width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin new image; honoured only in IDLE.
- pixel  in  PIX_W  current pixel value.
- weights  in  10*WT_W  class k weight in bits [WT_W*k+WT_W-1 : WT_W*k].
- in_valid  in  1  pixel/weights valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- busy  out  1  high in ACCUM and DRAIN.
- final0..final9  out  ACC_W each  class scores, registered.
- scores_valid  out  1  one-cycle pulse when final0..9 update.

Behaviour:
- Reset: state IDLE; beat counter, all 10 accumulators, product registers, final0..9, scores_valid, in_ready and busy all 0.
- States:
  - IDLE: in_ready=0. start=1 clears the accumulators and the counter, then moves to ACCUM next cycle.
  - ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready. After the beat with counter==N_IN-1 is accepted, move to DRAIN; in_ready=0 from the next cycle.
  - DRAIN: one cycle to add the final product. Then load final0..9 from the accumulators, pulse scores_valid, and return to IDLE.
- Pipeline:
  - Stage 1 registers prod_k = pixel*weight_k (PIX_W+WT_W bits) and a product-valid flag.
  - Stage 2 sets acc_k += prod_k when product-valid is high.
  - Last beat accepted at cycle T -> accumulation at T+1 -> final0..9 and scores_valid=1 visible at T+2.
- Throughput: 1 beat/cycle. Gaps in in_valid stall the counter only; an unaccepted beat adds nothing.
- Arithmetic: unsigned, zero-extended to ACC_W. The default worst case is 784*255*255 = 50,979,600 < 2^26, so no overflow. For other parameters, the accumulator saturates at 2^ACC_W-1 and never wraps.
- final0..9 hold their values until the next scores_valid. A new start does not clear them.
- start while busy is ignored. start in the same cycle scores_valid pulses (IDLE re-entry) is not honoured; it must be reissued.
- in_valid while in_ready=0 is ignored and produces no accumulation.
- Reset mid-image (ACCUM or DRAIN): immediate return to IDLE, everything cleared including final0..9. No scores_valid pulse.
- Counter width is clog2(N_IN). It is cleared only on start or reset and never wraps within an image.

Test Plan:
- N_IN=4. Pixels 1,2,3,4 with weight_k = k for every pixel -> final_k = 10*k (final9 = 90). scores_valid is one pulse, 2 cycles after the 4th beat.
- N_IN=4. in_valid deasserted for 3 cycles between beats 2 and 3 -> same results as the gapless run. in_ready stays 1 through the gap.
- Default N_IN=784, all pixels 255, all weights 255 -> every final = 50,979,600. No saturation.
- ACC_W=12, N_IN=4, pixel 255, weight 255 -> final = 4095 (saturated).
- Reset asserted after beat 2 of 4 -> outputs 0 next cycle, no scores_valid. A following start plus 4 beats gives correct fresh scores.
- start pulsed during ACCUM -> ignored; counter and accumulators unaffected. Second image after valid -> finals hold the old values until the new scores_valid.
